regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard.sv | 70 +++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with a hardwired zero register, synchronous clear and a per-register busy scoreboard
// Ports: clk/reset (sync, active-low); RegWrite/WriteRegister/WriteData write port;
// Reserve/ReserveRegister mark a register busy; ReadRegister -> ReadData/ReadBusy per read port;
// BusyCount is the registered population count of the busy bits.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data and post-edge busy to read ports.
module regfile_scoreboard #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 31,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RegWrite,
  input  logic [AW-1:0]             WriteRegister,
  input  logic [WIDTH-1:0]          WriteData,
  input  logic                      Reserve,
  input  logic [AW-1:0]             ReserveRegister,
  input  logic [NUM_READ*AW-1:0]    ReadRegister,
  output logic [NUM_READ*WIDTH-1:0] ReadData,
  output logic [NUM_READ-1:0]       ReadBusy,
  output logic [AW:0]               BusyCount
);
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy, w_busy_nxt;
  logic [AW:0] r_count, w_count;
  logic w_wr_ok, w_rsv_ok;
  function automatic logic f_ok(input logic [AW-1:0] a);
    return a != AW'(ZERO_REG) && {1'b0, a} < (AW+1)'(DEPTH);
  endfunction
  assign w_wr_ok = RegWrite && f_ok(WriteRegister);
  assign w_rsv_ok = Reserve && f_ok(ReserveRegister);
  always_comb begin
    w_busy_nxt = r_busy;
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy_nxt[i] = (w_rsv_ok && ReserveRegister == AW'(i)) ? 1'b1 :
                      (w_wr_ok && WriteRegister == AW'(i)) ? 1'b0 : r_busy[i];
      w_count = w_count + (AW+1)'(w_busy_nxt[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_regs[WriteRegister] <= WriteData;
      r_busy <= w_busy_nxt;
      r_count <= w_count;
    end
  end
  assign BusyCount = r_count;
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic w_ok;
    assign w_ra = ReadRegister[k*AW +: AW];
    assign w_ok = f_ok(w_ra);
`ifdef REGFILE_WRITE_BYPASS_EN
    logic w_byp;
    assign w_byp = w_wr_ok && WriteRegister == w_ra;
    assign ReadData[k*WIDTH +: WIDTH] = !w_ok ? '0 : w_byp ? WriteData : r_regs[w_ra];
    assign ReadBusy[k] = w_ok && w_busy_nxt[w_ra];
`else
    assign ReadData[k*WIDTH +: WIDTH] = w_ok ? r_regs[w_ra] : '0;
    assign ReadBusy[k] = w_ok && r_busy[w_ra];
`endif
  end
endmodule
